// File: rtl/ohsm_seq.sv
// ohsm_seq: parametrised one-hot sequencer with step/auto (dwell-timed) advance, loop and abort.
// Optional one-hot integrity checker and sticky err flag enabled by defining OHSM_ONEHOT_CHECK_EN.
module ohsm_seq #(
   parameter int NUM_STATES = 8,
   parameter int DWELL_W    = 8,
   parameter int SG_W       = $clog2(NUM_STATES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  auto_mode,
   input  logic                  loop_en,
   input  logic [DWELL_W-1:0]    dwell_cfg,
   output logic [NUM_STATES-1:0] state_oh,
   output logic [SG_W-1:0]       SGlobal,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [NUM_STATES-1:0] S0_OH = {{(NUM_STATES-1){1'b0}}, 1'b1};
   localparam logic [NUM_STATES-1:0] S1_OH = {{(NUM_STATES-2){1'b0}}, 2'b10};

   logic [DWELL_W-1:0]    cnt_reg;
   logic [DWELL_W-1:0]    cnt_next;
   logic [NUM_STATES-1:0] oh_next;
   logic [SG_W-1:0]       sg_next;
   logic                  done_next;
   logic                  adv;

`ifdef OHSM_ONEHOT_CHECK_EN
   // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
   logic oh_ok;
   assign oh_ok = (state_oh != '0) && ((state_oh & (state_oh - 1'b1)) == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err <= 1'b0;
      end else if (!oh_ok) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

   always_comb begin
      oh_next   = state_oh;
      cnt_next  = cnt_reg;
      done_next = 1'b0;
      adv       = 1'b0;
      if (abort) begin
         oh_next  = S0_OH;
         cnt_next = '0;
      end else if (state_oh[0]) begin
         if (start) begin
            oh_next  = S1_OH;
            cnt_next = dwell_cfg;
         end
      end else begin
         // Step mode leaves the counter frozen so a later switch to auto resumes it.
         if (auto_mode) begin
            if (cnt_reg == '0) begin
               adv = 1'b1;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end else begin
            adv = start;
         end
         if (adv) begin
            if (state_oh[NUM_STATES-1]) begin
               if (loop_en) begin
                  oh_next  = S1_OH;
                  cnt_next = dwell_cfg;
               end else begin
                  oh_next   = S0_OH;
                  cnt_next  = '0;
                  done_next = 1'b1;
               end
            end else begin
               oh_next  = {state_oh[NUM_STATES-2:0], 1'b0};
               cnt_next = dwell_cfg;
            end
         end
      end
`ifdef OHSM_ONEHOT_CHECK_EN
      if (!oh_ok) begin
         oh_next   = S0_OH;
         cnt_next  = '0;
         done_next = 1'b0;
      end
`endif
   end

   // SGlobal is encoded from the next one-hot vector so both registers always agree.
   logic [SG_W-1:0][NUM_STATES-1:0] enc_terms;
   genvar gi, gk;
   generate
      for (gi = 0; gi < SG_W; gi++) begin : g_enc_bit
         for (gk = 0; gk < NUM_STATES; gk++) begin : g_enc_term
            if (((gk >> gi) & 1) == 1) begin : g_on
               assign enc_terms[gi][gk] = oh_next[gk];
            end else begin : g_off
               assign enc_terms[gi][gk] = 1'b0;
            end
         end
         assign sg_next[gi] = |enc_terms[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_oh <= S0_OH;
         SGlobal  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         cnt_reg  <= '0;
      end else begin
         state_oh <= oh_next;
         SGlobal  <= sg_next;
         busy     <= ~oh_next[0];
         done     <= done_next;
         cnt_reg  <= cnt_next;
      end
   end

endmodule

// File: tb/tb_ohsm_seq.sv
// tb_ohsm_seq: directed stimulus for ohsm_seq with a cycle-level behavioural model and literal checks.
// Runs the one-hot injection test only when OHSM_ONEHOT_CHECK_EN is defined.
module tb_ohsm_seq;

   localparam int N  = 8;
   localparam int DW = 8;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          auto_mode = 1'b0;
   logic          loop_en = 1'b0;
   logic [DW-1:0] dwell_cfg = '0;
   logic [N-1:0]  state_oh;
   logic [SW-1:0] SGlobal;
   logic          busy;
   logic          done;
   logic          err;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;
   bit inj      = 1'b0;

   // Model state: index of the active state and cycles left before an auto advance.
   int m_idx  = 0;
   int m_left = 0;
   bit m_done = 1'b0;
   bit m_err  = 1'b0;

   ohsm_seq #(.NUM_STATES(N), .DWELL_W(DW), .SG_W(SW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .auto_mode (auto_mode),
      .loop_en   (loop_en),
      .dwell_cfg (dwell_cfg),
      .state_oh  (state_oh),
      .SGlobal   (SGlobal),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge reset) begin
      bit adv;
      if (!reset) begin
         m_idx = 0; m_left = 0; m_done = 1'b0; m_err = 1'b0;
      end else begin
         m_done = 1'b0;
         if (inj) begin
            m_idx = 0; m_left = 0; m_err = 1'b1;
         end else if (abort) begin
            m_idx = 0; m_left = 0;
         end else if (m_idx == 0) begin
            if (start) begin
               m_idx = 1; m_left = int'(dwell_cfg);
            end
         end else begin
            adv = auto_mode ? (m_left == 0) : start;
            if (auto_mode && m_left > 0) m_left = m_left - 1;
            if (adv) begin
               if (m_idx < N - 1) begin
                  m_idx = m_idx + 1; m_left = int'(dwell_cfg);
               end else if (loop_en) begin
                  m_idx = 1; m_left = int'(dwell_cfg);
               end else begin
                  m_idx = 0; m_done = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [N-1:0] e_oh;
      if (chk_en) begin
         e_oh = '0;
         e_oh[m_idx] = 1'b1;
         n_checks++;
         if (state_oh !== e_oh || int'(SGlobal) != m_idx || busy !== (m_idx != 0) ||
             done !== m_done || err !== m_err) begin
            n_err++;
            $display("FAIL cycle_cmp t=%0t: got oh=%b sg=%0d busy=%b done=%b err=%b, required oh=%b sg=%0d busy=%b done=%b err=%b",
                     $time, state_oh, SGlobal, busy, done, err, e_oh, m_idx, (m_idx != 0), m_done, m_err);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, got, exp);
      end else begin
         $display("check %s ok (%0d)", name, got);
      end
   endtask

   initial begin
      int cnt [N];
      int ndone;
      int exp_seq [9];

      // Reset held two cycles.
      repeat (2) step();
      check("rst_oh", int'(state_oh), 1);
      check("rst_sg", int'(SGlobal), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      reset = 1'b1;
      chk_en = 1'b1;
      step();

      // Step mode single pass.
      auto_mode = 1'b0; loop_en = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      check("step_s1", int'(SGlobal), 1);
      step();
      for (int k = 2; k < N; k++) begin
         start = 1'b1; step(); start = 1'b0;
         check("step_sk", int'(SGlobal), k);
         step();
      end
      start = 1'b1; step(); start = 1'b0;
      check("step_end_sg", int'(SGlobal), 0);
      check("step_end_done", int'(done), 1);
      check("step_end_busy", int'(busy), 0);
      step();
      check("step_done_1cyc", int'(done), 0);

      // Auto timing, dwell 2: each state 3 cycles, 21 busy cycles, one done.
      auto_mode = 1'b1; dwell_cfg = 8'd2;
      start = 1'b1; step(); start = 1'b0;
      foreach (cnt[i]) cnt[i] = 0;
      ndone = 0;
      for (int i = 0; i < 30; i++) begin
         if (SGlobal != 0) cnt[SGlobal]++;
         if (done) ndone++;
         step();
      end
      for (int k = 1; k < N; k++) check("auto_dwell", cnt[k], 3);
      check("auto_done_cnt", ndone, 1);

      // Loop wrap, dwell 0.
      dwell_cfg = 8'd0; loop_en = 1'b1;
      exp_seq = '{1, 2, 3, 4, 5, 6, 7, 1, 2};
      start = 1'b1; step(); start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 9; i++) begin
         check("loop_seq", int'(SGlobal), exp_seq[i]);
         if (done || !busy) ndone++;
         step();
      end
      check("loop_no_done_busy", ndone, 0);
      abort = 1'b1; step(); abort = 1'b0;
      check("loop_abort", int'(state_oh), 1);

      // Abort in S4 with dwell 5, then abort+start in S0.
      loop_en = 1'b0; dwell_cfg = 8'd5;
      start = 1'b1; step(); start = 1'b0;
      repeat (18) step();
      check("abort_in_s4", int'(SGlobal), 4);
      abort = 1'b1; start = 1'b1; step();
      check("abort_oh", int'(state_oh), 1);
      check("abort_sg", int'(SGlobal), 0);
      check("abort_done", int'(done), 0);
      step();
      check("abort_start_s0", int'(state_oh), 1);
      abort = 1'b0; start = 1'b0; step();

      // Mode changes and dwell_cfg changes mid-state, checked by the model.
      dwell_cfg = 8'd3;
      start = 1'b1; step(); start = 1'b0;
      step();
      auto_mode = 1'b0; dwell_cfg = 8'd1;
      repeat (4) step();
      auto_mode = 1'b1;
      repeat (3) step();
      check("resume_sg", int'(SGlobal), 2);
      start = 1'b1; repeat (3) step(); start = 1'b0;
      auto_mode = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      step();

      // Asynchronous reset mid-sequence.
      reset = 1'b0;
      #2;
      check("async_rst_oh", int'(state_oh), 1);
      check("async_rst_busy", int'(busy), 0);
      step();
      reset = 1'b1;
      step();

`ifdef OHSM_ONEHOT_CHECK_EN
      // Illegal one-hot injection.
      auto_mode = 1'b1; dwell_cfg = 8'd4;
      start = 1'b1; step(); start = 1'b0;
      chk_en = 1'b0; inj = 1'b1;
      force dut.state_oh = 8'b00010100;
      step();
      release dut.state_oh;
      step();
      inj = 1'b0; chk_en = 1'b1;
      check("inj_oh", int'(state_oh), 1);
      check("inj_sg", int'(SGlobal), 0);
      check("inj_err", int'(err), 1);
      start = 1'b1; step(); start = 1'b0;
      repeat (6) step();
      check("inj_err_sticky", int'(err), 1);
      reset = 1'b0; step();
      check("inj_err_clr", int'(err), 0);
      reset = 1'b1; step();
`else
      auto_mode = 1'b1; dwell_cfg = 8'd1;
      start = 1'b1; step(); start = 1'b0;
      repeat (5) step();
      check("err_tied_0", int'(err), 0);
`endif

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/ohsm_seq.md
Name: ohsm_seq

Overview:
- Parametrised successor to the fixed 3-bit one-hot state machine.
- One-hot sequencer with NUM_STATES states: S0 is idle, S1..S(N-1) are active.
- Advances either on start pulses (step mode) or automatically after a programmable per-state dwell (auto mode).
- Supports single-pass or looping sequences, abort, a done pulse and an encoded SGlobal output for downstream decode.

Parameters:
- NUM_STATES, 8, total states including idle S0; legal range 3..32.
- DWELL_W, 8, width of dwell counter and dwell_cfg.
- SG_W, $clog2(NUM_STATES), width of encoded state output SGlobal.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  level sampled each clk; in S0 launches a sequence; in step mode advances one state.
- abort  in  1  forces return to S0 next edge; highest priority after reset.
- auto_mode  in  1  0 = step mode, 1 = auto (dwell-timed) mode; sampled every cycle.
- loop_en  in  1  1 = after S(N-1) wrap to S1; 0 = return to S0 with done.
- dwell_cfg  in  DWELL_W  dwell per active state in auto mode: state lasts dwell_cfg+1 cycles.
- state_oh  out  NUM_STATES  one-hot state vector; bit k = Sk.
- SGlobal  out  SG_W  binary index of current state; always consistent with state_oh.
- busy  out  1  high whenever state is not S0.
- done  out  1  one-cycle pulse on completion of single-pass sequence.
- err  out  1  sticky illegal-state flag (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): state_oh = 1 (S0), SGlobal = 0, busy = 0, done = 0, err = 0, dwell counter = 0. Outputs hold reset values until the first edge after reset deasserts.
- All outputs are registered; zero combinational input-to-output paths. SGlobal and busy update on the same edge as state_oh.
- Priority each edge: abort > start/auto advance > hold.
- S0: start=1 and abort=0 -> S1, dwell counter loaded with dwell_cfg. Otherwise hold.
- Sk (1 <= k <= N-1), step mode: start=1 -> advance. Each cycle start is high counts as one step (no edge detect). The dwell counter is ignored.
- Sk, auto mode: the counter decrements each cycle. When the counter is 0 -> advance, reloading dwell_cfg on entry to the next state. start is ignored outside S0.
- Advance from Sk, k < N-1: go to S(k+1).
- Advance from S(N-1):
  - loop_en=1 -> S1, done stays 0.
  - loop_en=0 -> S0, done=1 for exactly that one cycle.
- abort=1 in any state -> S0 next edge. done=0, counter cleared. abort in S0 with start=1 keeps S0.
- Mode change mid-state: switching auto->step freezes the counter. Switching step->auto resumes the counter from its current value.
- dwell_cfg is sampled only at state entry; changes mid-state take effect at the next entry.
- dwell_cfg = 0 in auto mode: each active state lasts exactly 1 cycle.
- Reset asserted mid-sequence: immediate return to S0 with all outputs at reset values; err is cleared.

Optional Feature:
- Macro: OHSM_ONEHOT_CHECK_EN.
- Defined:
  - Each cycle, the block checks that state_oh is exactly one-hot.
  - On a violation (zero bits or more than one bit set), the next edge forces S0 and sets err=1.
  - err is sticky until reset.
  - SGlobal reads 0 during the recovery cycle.
- Not defined: no checker logic; err is tied to 0; an illegal state_oh has undefined behaviour.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release -> state_oh=8'b00000001, SGlobal=0, busy=0, done=0, err=0.
- Step single pass (auto_mode=0, loop_en=0): start high 1 cycle, then 7 further 1-cycle start pulses -> SGlobal steps 1..7. Final pulse -> SGlobal=0, done=1 for exactly 1 cycle, busy=0.
- Auto timing (auto_mode=1, dwell_cfg=2, loop_en=0): start 1 cycle -> each of S1..S7 held exactly 3 cycles (21 cycles total); done pulses on return to S0.
- Loop wrap (auto_mode=1, dwell_cfg=0, loop_en=1): start -> SGlobal sequence 1,2,...,7,1,2 on consecutive cycles; done never asserts; busy stays 1.
- Abort: in S4 (auto, dwell_cfg=5), assert abort with start=1 -> next edge state_oh=1, SGlobal=0, done=0. Abort+start in S0 -> remains S0.
- With OHSM_ONEHOT_CHECK_EN: force state_oh=8'b00010100 for one cycle, release -> next edge S0, err=1, err persists until reset=0. Without the macro, err stays 0.
